// File: rtl/median_pkg.sv
// Shared types and constants for the streaming 3x3 median filter.
// The border-select helper turns a position flag plus frame mode into the output mux select.
package median_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    typedef enum logic [1:0] {SEL_MED, SEL_CTR, SEL_ZERO} sel_t;

    localparam logic BORDER_PASS = 1'b0;
    localparam logic BORDER_ZERO = 1'b1;
    localparam int   MED_LAT     = 3;

    function automatic sel_t border_sel(input logic is_border, input logic mode);
        if (!is_border) return SEL_MED;
        return (mode == BORDER_ZERO) ? SEL_ZERO : SEL_CTR;
    endfunction

endpackage

// File: rtl/med9_sort.sv
// Median-of-9 via the 19 compare-exchange network, split into three register stages.
// Valid, start-of-frame and border select ride alongside; i_clr drops everything in flight.
module med9_sort
    import median_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_clr,
    input  logic                  i_valid,
    input  logic [8:0][WIDTH-1:0] i_win,
    input  sel_t                  i_sel,
    input  logic                  i_sof,
    output logic                  o_valid,
    output logic                  o_sof,
    output sel_t                  o_sel,
    output logic [WIDTH-1:0]      o_med,
    output logic [WIDTH-1:0]      o_ctr,
    output logic                  o_busy
);

    typedef logic [8:0][WIDTH-1:0] vec_t;

    function automatic vec_t cx(input vec_t v, input int a, input int b);
        vec_t t = v;
        if (v[a] > v[b]) begin
            t[a] = v[b];
            t[b] = v[a];
        end
        return t;
    endfunction

    vec_t w_s1, w_s2, w_s3;
    vec_t r_s1, r_s2;
    logic [WIDTH-1:0] r_med, r_c1, r_c2, r_c3;
    sel_t r_sel1, r_sel2, r_sel3;
    logic r_sof1, r_sof2, r_sof3;
    logic r_v1, r_v2, r_v3;

    // NOTE: combinational chains use blocking '=' so each step sees the previous one;
    // state in always_ff always uses '<='.
    always_comb begin
        w_s1 = i_win;
        w_s1 = cx(w_s1, 1, 2); w_s1 = cx(w_s1, 4, 5); w_s1 = cx(w_s1, 7, 8);
        w_s1 = cx(w_s1, 0, 1); w_s1 = cx(w_s1, 3, 4); w_s1 = cx(w_s1, 6, 7);
        w_s1 = cx(w_s1, 1, 2); w_s1 = cx(w_s1, 4, 5); w_s1 = cx(w_s1, 7, 8);
    end

    always_comb begin
        w_s2 = r_s1;
        w_s2 = cx(w_s2, 0, 3); w_s2 = cx(w_s2, 5, 8); w_s2 = cx(w_s2, 4, 7);
        w_s2 = cx(w_s2, 3, 6); w_s2 = cx(w_s2, 1, 4); w_s2 = cx(w_s2, 2, 5);
        w_s2 = cx(w_s2, 4, 7);
    end

    always_comb begin
        w_s3 = r_s2;
        w_s3 = cx(w_s3, 4, 2); w_s3 = cx(w_s3, 6, 4); w_s3 = cx(w_s3, 4, 2);
    end

    always_ff @(posedge CLK) begin
        if (RST || i_clr) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // Data stages only load behind a valid beat; bubbles leave them frozen.
    always_ff @(posedge CLK) begin
        if (i_valid) begin
            r_s1   <= w_s1;
            r_c1   <= i_win[4];
            r_sel1 <= i_sel;
            r_sof1 <= i_sof;
        end
        if (r_v1) begin
            r_s2   <= w_s2;
            r_c2   <= r_c1;
            r_sel2 <= r_sel1;
            r_sof2 <= r_sof1;
        end
        if (r_v2) begin
            r_med  <= w_s3[4];
            r_c3   <= r_c2;
            r_sel3 <= r_sel2;
            r_sof3 <= r_sof2;
        end
    end

    assign o_valid = r_v3;
    assign o_sof   = r_sof3;
    assign o_sel   = r_sel3;
    assign o_med   = r_med;
    assign o_ctr   = r_c3;
    assign o_busy  = r_v1 | r_v2 | r_v3;

endmodule

// File: rtl/median_stream_3x3.sv
// Pixel-serial 3x3 median filter: two line buffers, a sliding window, border handling
// and an end-of-frame flush so every input pixel yields exactly one output pixel.
module median_stream_3x3
    import median_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COL   = 512,
    parameter int ROW   = 512
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_pixel,
    output logic             in_ready,
    input  logic             border_mode,
    output logic             out_valid,
    output logic             out_sof,
    output logic [WIDTH-1:0] out_pixel,
    output logic             busy
);

    localparam int CW  = $clog2(COL);
    localparam int RIW = $clog2(ROW + 2);
    localparam int ROW_W = $clog2(ROW);
    localparam logic [CW-1:0]    C_LAST  = CW'(COL - 1);
    localparam logic [RIW-1:0]   RI_LAST = RIW'(ROW - 1);
    localparam logic [RIW-1:0]   RI_END  = RIW'(ROW + 1);
    localparam logic [ROW_W-1:0] RO_LAST = ROW_W'(ROW - 1);

    state_t r_state, w_next;
    logic [RIW-1:0]   r_in;
    logic [CW-1:0]    r_cin, r_cout;
    logic [ROW_W-1:0] r_rout;
    logic             r_mode;

    logic [WIDTH-1:0]      r_lb1 [COL];
    logic [WIDTH-1:0]      r_lb2 [COL];
    logic [8:0][WIDTH-1:0] r_win;
    logic                  r_win_valid, r_win_sof;
    sel_t                  r_win_sel;

    logic w_acc, w_sof_beat, w_px_beat, w_fl_beat, w_beat, w_abort;
    logic w_fill_done, w_last_px, w_launch, w_border;
    logic [CW-1:0]    w_col;
    logic [WIDTH-1:0] w_pix;
    logic             w_s_valid, w_s_sof, w_s_busy;
    sel_t             w_s_sel;
    logic [WIDTH-1:0] w_s_med, w_s_ctr;

    assign w_acc       = in_valid && in_ready;
    assign w_sof_beat  = w_acc && in_sof;
    assign w_px_beat   = w_acc && !in_sof && (r_state == FILL || r_state == RUN);
    assign w_fl_beat   = (r_state == FLUSH);
    assign w_beat      = w_sof_beat || w_px_beat || w_fl_beat;
    assign w_abort     = w_sof_beat && (r_state != IDLE);
    assign w_fill_done = (r_in == RIW'(1)) && (r_cin == CW'(1));
    assign w_last_px   = (r_in == RI_LAST) && (r_cin == C_LAST);
    assign w_launch    = w_fl_beat || (w_px_beat && (r_state == RUN || w_fill_done));
    assign w_col       = w_sof_beat ? '0 : r_cin;
    assign w_pix       = w_fl_beat ? '0 : in_pixel;
    assign w_border    = (r_rout == '0) || (r_rout == RO_LAST) ||
                         (r_cout == '0) || (r_cout == C_LAST);

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        w_next = r_state;
        if (w_sof_beat) begin
            w_next = FILL;
        end else begin
            unique case (r_state)
                IDLE:  w_next = IDLE;
                FILL:  if (w_px_beat && w_fill_done) w_next = RUN;
                RUN:   if (w_px_beat && w_last_px)   w_next = FLUSH;
                FLUSH: if (r_in == RI_END)           w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (r_state != FLUSH);
    end

    // Input counters run on through the flush so the line buffers keep feeding the window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_in   <= '0;
            r_cin  <= '0;
            r_rout <= '0;
            r_cout <= '0;
            r_mode <= BORDER_PASS;
        end else if (w_sof_beat) begin
            r_in   <= '0;
            r_cin  <= CW'(1);
            r_rout <= '0;
            r_cout <= '0;
            r_mode <= border_mode;
        end else begin
            if (w_px_beat || w_fl_beat) begin
                if (r_cin == C_LAST) begin
                    r_cin <= '0;
                    r_in  <= r_in + RIW'(1);
                end else begin
                    r_cin <= r_cin + CW'(1);
                end
            end
            if (w_launch) begin
                if (r_cout == C_LAST) begin
                    r_cout <= '0;
                    r_rout <= r_rout + ROW_W'(1);
                end else begin
                    r_cout <= r_cout + CW'(1);
                end
            end
        end
    end

    // NOTE: line buffers and window data carry no reset; only the valid bits need one.
    always_ff @(posedge CLK) begin
        if (w_beat) begin
            r_lb2[w_col] <= r_lb1[w_col];
            r_lb1[w_col] <= w_pix;
            for (int i = 0; i < 3; i++) begin
                r_win[3*i]   <= r_win[3*i+1];
                r_win[3*i+1] <= r_win[3*i+2];
            end
            r_win[2] <= r_lb2[w_col];
            r_win[5] <= r_lb1[w_col];
            r_win[8] <= w_pix;
        end
        if (w_launch) begin
            r_win_sel <= border_sel(w_border, r_mode);
            r_win_sof <= (r_rout == '0) && (r_cout == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) r_win_valid <= 1'b0;
        else     r_win_valid <= w_launch;
    end

    med9_sort #(.WIDTH(WIDTH)) u_sort (
        .CLK     (CLK),
        .RST     (RST),
        .i_clr   (w_abort),
        .i_valid (r_win_valid),
        .i_win   (r_win),
        .i_sel   (r_win_sel),
        .i_sof   (r_win_sof),
        .o_valid (w_s_valid),
        .o_sof   (w_s_sof),
        .o_sel   (w_s_sel),
        .o_med   (w_s_med),
        .o_ctr   (w_s_ctr),
        .o_busy  (w_s_busy)
    );

    always_comb begin
        out_pixel = '0;
        if (w_s_valid) begin
            case (w_s_sel)
                SEL_CTR:  out_pixel = w_s_ctr;
                SEL_ZERO: out_pixel = '0;
                default:  out_pixel = w_s_med;
            endcase
        end
    end

    assign out_valid = w_s_valid;
    assign out_sof   = w_s_valid && w_s_sof;
    assign busy      = (r_state != IDLE) || r_win_valid || w_s_busy;

endmodule

// File: tb/tb_median_stream_3x3.sv
// Scoreboard bench for median_stream_3x3 at COL=ROW=4: stimulus pushes expected pixels,
// an independent monitor pops and compares whenever out_valid is seen.
module tb_median_stream_3x3;

    localparam int W = 8;
    localparam int C = 4;
    localparam int R = 4;
    localparam int N = C * R;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sof = 1'b0;
    logic [W-1:0] in_pixel = '0;
    logic         border_mode = 1'b0;
    logic         in_ready, out_valid, out_sof, busy;
    logic [W-1:0] out_pixel;

    median_stream_3x3 #(.WIDTH(W), .COL(C), .ROW(R)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_pixel    (in_pixel),
        .in_ready    (in_ready),
        .border_mode (border_mode),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_pixel   (out_pixel),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0] pix;
        logic         sof;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           sof_in_cyc = 0;
    int           sof_out_cyc = -100;
    bit           sb_ignore = 1'b0;
    logic [W-1:0] stim [N];
    logic [W-1:0] expv [N];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented output must match the head of the scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        if (out_valid === 1'b1 && !sb_ignore) begin
            if (out_sof === 1'b1) sof_out_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_output", out_pixel, 32'hDEAD);
            end else begin
                e = sb.pop_front();
                check("out_pixel", out_pixel, e.pix);
                check("out_sof", out_sof, e.sof);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [W-1:0] p, input logic sof);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) check("in_ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = p;
        if (sof) sof_in_cyc = cyc;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic mode, input int gap);
        border_mode = mode;
        for (int i = 0; i < N; i++) begin
            send(stim[i], i == 0);
            if (i != N - 1) repeat (gap) tick();
        end
    endtask

    task automatic expect_frame();
        for (int i = 0; i < N; i++) sb.push_back('{pix: expv[i], sof: (i == 0)});
    endtask

    task automatic drain();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_busy", busy, 0);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic fill_const(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) begin
            stim[i] = v;
            expv[i] = v;
        end
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_pixel", out_pixel, 0);
        RST = 1'b0;
        tick();

        // Constant 0x55, mode 0, continuous beats
        fill_const(8'h55);
        expect_frame();
        send_frame(1'b0, 0);
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            n++;
            tick();
        end
        check("flush_ready_low_cycles", n, 5);
        drain();
        check("sof_latency", sof_out_cyc - sof_in_cyc, 9);

        // Zero frame with an impulse at (1,1): median removes it
        fill_const(8'h00);
        stim[5] = 8'hFF;
        expect_frame();
        send_frame(1'b0, 0);
        drain();

        // Constant 0x55, mode 1: borders forced to zero
        fill_const(8'h55);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (r == 0 || r == R - 1 || c == 0 || c == C - 1) expv[r*C+c] = 8'h00;
        expect_frame();
        send_frame(1'b1, 0);
        drain();

        // Ramp 16r+c with in_valid every other cycle: median of a ramp is its centre
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                stim[r*C+c] = W'(16 * r + c);
                expv[r*C+c] = W'(16 * r + c);
            end
        expect_frame();
        send_frame(1'b0, 1);
        drain();

        // Abort at index 7, then a full 0x33 frame
        border_mode = 1'b0;
        for (int i = 0; i < 7; i++) send(8'h77, i == 0);
        fill_const(8'h33);
        expect_frame();
        send_frame(1'b0, 0);
        drain();

        // Reset pulse during FLUSH
        sb_ignore = 1'b1;
        fill_const(8'h44);
        send_frame(1'b0, 0);
        check("in_flush_before_rst", in_ready, 0);
        tick();
        RST = 1'b1;
        tick();
        check("midflush_rst_out_valid", out_valid, 0);
        check("midflush_rst_busy", busy, 0);
        check("midflush_rst_in_ready", in_ready, 1);
        check("midflush_rst_out_sof", out_sof, 0);
        check("midflush_rst_out_pixel", out_pixel, 0);
        RST = 1'b0;
        tick();
        sb_ignore = 1'b0;

        // Mixed frame after reset: interior medians differ from the centres
        stim = '{8'd10, 8'd20, 8'd30, 8'd40,
                 8'd50, 8'd90, 8'd10, 8'd60,
                 8'd70, 8'd20, 8'd80, 8'd30,
                 8'd15, 8'd25, 8'd35, 8'd45};
        expv = '{8'd10, 8'd20, 8'd30, 8'd40,
                 8'd50, 8'd30, 8'd30, 8'd60,
                 8'd70, 8'd35, 8'd35, 8'd30,
                 8'd15, 8'd25, 8'd35, 8'd45};
        expect_frame();
        send_frame(1'b0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/median_stream_3x3.md
# median_stream_3x3

Streaming, parametrised 3×3 median filter for raster video. It is the pixel-serial successor of the row-parallel 3×512 median datapath. It accepts one pixel per beat and keeps two line buffers internally. Selectable border handling and an automatic end-of-frame flush produce exactly one output pixel per input pixel, in raster order. It sits between the pixel source and the frame writer.

## Interface
- `WIDTH`, 8: pixel bit width.
- `COL`, 512: pixels per row (≥3).
- `ROW`, 512: rows per frame (≥3).
- `CLK` in 1: clock. One clock; all logic on the rising edge.
- `RST` in 1: reset. Synchronous, active-high.
- `in_valid` in 1: input pixel valid.
- `in_sof` in 1: input start of frame, qualifies pixel (0,0).
- `in_pixel` in WIDTH: input pixel.
- `in_ready` out 1: block accepts input. Beat accepted when `in_valid && in_ready`.
- `border_mode` in 1: 0 = border pixels pass through unchanged; 1 = border pixels output 0. Sampled on the accepted SOF beat.
- `out_valid` out 1: output pixel valid.
- `out_sof` out 1: marks output pixel (0,0).
- `out_pixel` out WIDTH: filtered pixel.
- `busy` out 1: frame in progress (state ≠ IDLE, or pipeline not empty).

## Operation
- FSM states:
  - IDLE: `in_ready`=1. Non-SOF beats are dropped. An accepted SOF beat clears the counters, latches `border_mode` and goes to FILL.
  - FILL: accepts pixels until index COL+1 (row 1, col 1) is written, then goes to RUN.
  - RUN: accepts the remaining pixels. On the last pixel (ROW-1, COL-1) it goes to FLUSH.
  - FLUSH: `in_ready`=0. The block internally generates COL+1 dummy beats, one per cycle, then returns to IDLE.
- Input counters `r_in`, `c_in` wrap c at COL-1. Output counters `r_out`, `c_out` track the emitted pixel.
- Line buffers: two COL-deep memories holding rows r-1 and r-2. The 3×3 window shifts one column per beat (input or flush).
- Each beat at input index k ≥ COL+1 launches the computation for output index k−(COL+1).
- Border pixels (r=0, r=ROW-1, c=0, c=COL-1) output the window centre (mode 0) or 0 (mode 1). Interior pixels output the median of 9.
- Median arithmetic: unsigned compare only, no widening. The result equals one of the 9 window values bit-exactly.
- Window columns that straddle a row wrap are only ever used for border pixels, so their contents are don't-care.
- SOF accepted while state ≠ IDLE aborts the frame:
  - In-flight pipeline results are discarded (no `out_valid`).
  - Counters restart and the new frame begins in FILL.
- Stalls: gaps in `in_valid` freeze the window and pipeline stages that have no new beat, so outputs simply arrive later. FLUSH beats never stall.
- Exactly ROW·COL outputs per completed frame. `out_sof` is asserted on the first output only.

## Timing
- Latency: `out_valid` for output index j is asserted 4 cycles after the beat with index j+COL+1 (1 window register plus 3 sort stages).
- Throughput: 1 pixel/cycle sustained. Between frames the dead time is COL+1 cycles (FLUSH), plus 4 cycles to drain.
- `in_ready` falls the cycle after the last pixel is accepted. It rises on the cycle the state returns to IDLE.
- Reset (including mid-frame or mid-flush) has effect the cycle after `RST`=1:
  - `out_valid`, `out_sof`, `out_pixel`, `busy` = 0.
  - `in_ready` = 1.
  - State = IDLE. Pipeline valid bits are cleared.
  - Line-buffer contents are not cleared.
- SOF and the last-pixel condition on the same beat cannot coincide, because ROW, COL ≥ 3.

## Structure
- Package `median_pkg`:
  - State enum `{IDLE, FILL, RUN, FLUSH}`.
  - Border-mode constants `BORDER_PASS`=0, `BORDER_ZERO`=1.
  - `MED_LAT`=3.
- Sub-module `med9_sort`:
  - Parametrised by WIDTH.
  - 19-compare-exchange median-of-9 network, registered in 3 stages.
  - Valid and border-select flags carried alongside the data.
- Top level: FSM, counters, line buffers, window registers, border mux.

## Test plan
All scenarios use COL=4, ROW=4, WIDTH=8.
- Constant frame of 0x55, mode 0, continuous `in_valid` → 16 outputs of 0x55. `out_sof` on the first output, 5+4 cycles after SOF. `in_ready` low for exactly 5 cycles after pixel 15.
- Zero frame with 0xFF at (1,1), mode 0 → all 16 outputs 0x00 (impulse removed).
- Constant 0x55, mode 1 → 12 border outputs 0x00. Interior (1,1),(1,2),(2,1),(2,2) = 0x55.
- Ramp pixel = 16·r+c with `in_valid` toggling every other cycle → interior outputs equal the centre values 0x11, 0x12, 0x21, 0x22 in order. No output lost or duplicated.
- SOF re-asserted at input index 7, then a full constant-0x33 frame → no outputs from the aborted frame after the abort. Then exactly 16 × 0x33, with `out_sof` once.
- `RST` pulsed during FLUSH → next cycle `out_valid`=0, `busy`=0, `in_ready`=1. A following frame filters correctly.
